// File: rtl/beat_collector.sv
// Packs BEATS consecutive qualified pixels into one word and writes it to the
// result memory, one address per group, from MINPIXEL up to MAXPIXEL per frame.
module beat_collector #(
  parameter int BEATS             = 4,
  parameter int PAUSE             = 1,
  parameter int PIXELWIDTH        = 8,
  parameter int PIXELCOUNTERWIDTH = 20,
  parameter int MINPIXEL          = 0,
  parameter int MAXPIXEL          = 255
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          started,
  input  logic                          process,
  input  logic [PIXELWIDTH-1:0]         pixelIn,
  output logic                          wrEn,
  output logic [PIXELCOUNTERWIDTH-1:0]  wrAddr,
  output logic [BEATS*PIXELWIDTH-1:0]   wrData,
  output logic                          busy,
  output logic                          done,
  output logic                          overrun,
  output logic                          truncated
);

  localparam int PW = PIXELWIDTH;
  localparam int AW = PIXELCOUNTERWIDTH;
  localparam int DW = BEATS * PIXELWIDTH;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int GW = $clog2(PAUSE + 2);

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [GW-1:0] PAUSE_C   = GW'(PAUSE);
  localparam logic [AW-1:0] MIN_C     = AW'(MINPIXEL);
  localparam logic [AW-1:0] MAX_C     = AW'(MAXPIXEL);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FLUSH, S_DONE} state_t;

  state_t          state_q;
  logic [BW-1:0]   beat_q;
  logic [GW-1:0]   gap_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   grp_q;
  logic            first_q;
  logic            wrEn_q;
  logic [AW-1:0]   wrAddr_q;
  logic [DW-1:0]   wrData_q;
  logic            busy_q;
  logic            done_q;
  logic            overrun_q;
  logic            truncated_q;

  logic [DW-1:0]   grp_d;
  logic [BW-1:0]   beat_d;
  logic            grp_full;

  // Group buffer with the current pixel merged in; beat count after this cycle.
  always_comb begin
    grp_d = grp_q;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_q == BW'(k)) grp_d[k*PW +: PW] = pixelIn;
    end
    grp_full = process && (beat_q == LAST_BEAT);
    beat_d   = beat_q;
    if (process) beat_d = grp_full ? '0 : beat_q + BW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      gap_q       <= '0;
      addr_q      <= MIN_C;
      grp_q       <= '0;
      first_q     <= 1'b1;
      wrEn_q      <= 1'b0;
      wrAddr_q    <= MIN_C;
      wrData_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      truncated_q <= 1'b0;
    end else begin
      wrEn_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (started) begin
            state_q     <= S_COLLECT;
            busy_q      <= 1'b1;
            addr_q      <= MIN_C;
            beat_q      <= '0;
            gap_q       <= '0;
            grp_q       <= '0;
            first_q     <= 1'b1;
            overrun_q   <= 1'b0;
            truncated_q <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (process) begin
            gap_q <= '0;
            // The very first group of a frame has no predecessor to be too close to.
            if (beat_q == '0 && !first_q && gap_q < PAUSE_C) overrun_q <= 1'b1;
            if (grp_full) begin
              wrEn_q   <= 1'b1;
              wrData_q <= grp_d;
              wrAddr_q <= addr_q;
              addr_q   <= addr_q + AW'(1);
              grp_q    <= '0;
              first_q  <= 1'b0;
            end else begin
              grp_q <= grp_d;
            end
            beat_q <= beat_d;
          end else if (gap_q < PAUSE_C) begin
            gap_q <= gap_q + GW'(1);
          end
          if (grp_full && addr_q == MAX_C) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
          end else if (!started) begin
            if (beat_d == '0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          // Unfilled lanes are already zero: the buffer is cleared after every write.
          wrEn_q      <= 1'b1;
          wrData_q    <= grp_q;
          wrAddr_q    <= addr_q;
          addr_q      <= addr_q + AW'(1);
          grp_q       <= '0;
          beat_q      <= '0;
          truncated_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wrEn      = wrEn_q;
  assign wrAddr    = wrAddr_q;
  assign wrData    = wrData_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;
  assign truncated = truncated_q;

endmodule

// File: tb/tb_beat_collector.sv
// Directed bench for beat_collector with default parameters.
module tb_beat_collector;

  logic        clk;
  logic        reset_n;
  logic        started;
  logic        process;
  logic [7:0]  pixelIn;
  logic        wrEn;
  logic [19:0] wrAddr;
  logic [31:0] wrData;
  logic        busy;
  logic        done;
  logic        overrun;
  logic        truncated;

  int n_assert = 0;
  int n_fail   = 0;

  beat_collector dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .started   (started),
    .process   (process),
    .pixelIn   (pixelIn),
    .wrEn      (wrEn),
    .wrAddr    (wrAddr),
    .wrData    (wrData),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun),
    .truncated (truncated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one clock edge; outputs are sampled 1 time unit after it.
  task automatic cyc(input logic st, input logic pr, input logic [7:0] px);
    started = st;
    process = pr;
    pixelIn = px;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_data;
  logic [7:0]  px;

  initial begin
    reset_n = 1'b0;
    started = 1'b0;
    process = 1'b0;
    pixelIn = 8'h00;

    // Reset state
    cyc(1'b1, 1'b1, 8'h5A);
    cyc(1'b1, 1'b1, 8'h5A);
    chk("rst_wrEn",      64'(wrEn),      64'd0);
    chk("rst_done",      64'(done),      64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_overrun",   64'(overrun),   64'd0);
    chk("rst_truncated", 64'(truncated), 64'd0);
    chk("rst_wrAddr",    64'(wrAddr),    64'd0);
    chk("rst_wrData",    64'(wrData),    64'd0);

    // Basic group: 11,22,33,44
    reset_n = 1'b1;
    cyc(1'b1, 1'b0, 8'h00);
    chk("start_busy", 64'(busy), 64'd1);
    cyc(1'b1, 1'b1, 8'h11);
    cyc(1'b1, 1'b1, 8'h22);
    cyc(1'b1, 1'b1, 8'h33);
    chk("basic_no_early_wr", 64'(wrEn), 64'd0);
    cyc(1'b1, 1'b1, 8'h44);
    chk("basic_wrEn",   64'(wrEn),   64'd1);
    chk("basic_wrAddr", 64'(wrAddr), 64'd0);
    chk("basic_wrData", 64'(wrData), 64'h44332211);
    cyc(1'b1, 1'b0, 8'h00);
    chk("basic_wrEn_drop",   64'(wrEn),    64'd0);
    chk("basic_wrData_hold", 64'(wrData),  64'h44332211);
    chk("basic_overrun",     64'(overrun), 64'd0);

    // Partial group then started falls: flush AA,BB at address 1
    cyc(1'b1, 1'b1, 8'hAA);
    cyc(1'b1, 1'b1, 8'hBB);
    cyc(1'b0, 1'b0, 8'h00);
    chk("flush_enter_wrEn", 64'(wrEn), 64'd0);
    chk("flush_enter_busy", 64'(busy), 64'd1);
    cyc(1'b0, 1'b0, 8'h00);
    chk("flush_wrEn",      64'(wrEn),      64'd1);
    chk("flush_wrData",    64'(wrData),    64'h0000BBAA);
    chk("flush_wrAddr",    64'(wrAddr),    64'd1);
    chk("flush_truncated", 64'(truncated), 64'd1);
    chk("flush_busy",      64'(busy),      64'd0);
    chk("flush_done_early", 64'(done),     64'd0);
    cyc(1'b0, 1'b0, 8'h00);
    chk("flush_done",      64'(done),      64'd1);
    chk("flush_wrEn_once", 64'(wrEn),      64'd0);
    cyc(1'b0, 1'b1, 8'hEE);
    chk("flush_done_pulse",  64'(done),      64'd0);
    chk("flush_trunc_stick", 64'(truncated), 64'd1);
    chk("idle_ignores_proc", 64'(busy),      64'd0);

    // Overrun: process held high across two groups
    cyc(1'b1, 1'b0, 8'h00);
    chk("ovr_start_trunc_clr", 64'(truncated), 64'd0);
    chk("ovr_start_ovr_clr",   64'(overrun),   64'd0);
    cyc(1'b1, 1'b1, 8'h01);
    cyc(1'b1, 1'b1, 8'h02);
    cyc(1'b1, 1'b1, 8'h03);
    cyc(1'b1, 1'b1, 8'h04);
    chk("ovr_g0_wrAddr", 64'(wrAddr),  64'd0);
    chk("ovr_g0_ovr",    64'(overrun), 64'd0);
    cyc(1'b1, 1'b1, 8'h05);
    chk("ovr_set", 64'(overrun), 64'd1);
    cyc(1'b1, 1'b1, 8'h06);
    cyc(1'b1, 1'b1, 8'h07);
    cyc(1'b1, 1'b1, 8'h08);
    chk("ovr_g1_wrEn",   64'(wrEn),   64'd1);
    chk("ovr_g1_wrAddr", 64'(wrAddr), 64'd1);
    chk("ovr_g1_wrData", 64'(wrData), 64'h08070605);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    chk("ovr_sticky", 64'(overrun), 64'd1);
    cyc(1'b0, 1'b0, 8'h00);
    chk("ovr_stop_no_wr", 64'(wrEn), 64'd0);
    cyc(1'b0, 1'b0, 8'h00);
    chk("ovr_done",       64'(done),      64'd1);
    chk("ovr_hold_done",  64'(overrun),   64'd1);
    chk("ovr_no_trunc",   64'(truncated), 64'd0);

    // Reset mid-group discards the partial group
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'hC1);
    cyc(1'b1, 1'b1, 8'hC2);
    cyc(1'b1, 1'b1, 8'hC3);
    reset_n = 1'b0;
    cyc(1'b1, 1'b1, 8'hC4);
    chk("mrst_wrEn",    64'(wrEn),    64'd0);
    chk("mrst_busy",    64'(busy),    64'd0);
    chk("mrst_wrAddr",  64'(wrAddr),  64'd0);
    chk("mrst_wrData",  64'(wrData),  64'd0);
    chk("mrst_overrun", 64'(overrun), 64'd0);
    reset_n = 1'b1;
    cyc(1'b0, 1'b1, 8'hD1);
    cyc(1'b0, 1'b1, 8'hD2);
    cyc(1'b0, 1'b1, 8'hD3);
    cyc(1'b0, 1'b1, 8'hD4);
    chk("mrst_idle_wrEn", 64'(wrEn), 64'd0);
    chk("mrst_idle_busy", 64'(busy), 64'd0);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'hE1);
    cyc(1'b1, 1'b1, 8'hE2);
    cyc(1'b1, 1'b1, 8'hE3);
    cyc(1'b1, 1'b1, 8'hE4);
    chk("mrst_restart_wrEn",   64'(wrEn),   64'd1);
    chk("mrst_restart_wrAddr", 64'(wrAddr), 64'd0);
    chk("mrst_restart_wrData", 64'(wrData), 64'hE4E3E2E1);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    chk("mrst_restart_done", 64'(done), 64'd1);

    // Full 256-group frame, 1111011110 pattern
    cyc(1'b1, 1'b0, 8'h00);
    for (int g = 0; g < 256; g++) begin
      exp_data = '0;
      for (int b = 0; b < 4; b++) begin
        px = 8'((g * 4 + b) & 255);
        exp_data[b*8 +: 8] = px;
        cyc(1'b1, 1'b1, px);
      end
      chk("frame_wrEn",   64'(wrEn),   64'd1);
      chk("frame_wrAddr", 64'(wrAddr), 64'(g));
      chk("frame_wrData", 64'(wrData), 64'(exp_data));
      if (g == 255) chk("frame_done_early", 64'(done), 64'd0);
      cyc(1'b1, 1'b0, 8'h00);
    end
    chk("frame_done",      64'(done),    64'd1);
    chk("frame_overrun",   64'(overrun), 64'd0);
    chk("frame_busy",      64'(busy),    64'd0);
    chk("frame_last_wrEn", 64'(wrEn),    64'd0);
    cyc(1'b0, 1'b1, 8'h77);
    cyc(1'b0, 1'b1, 8'h78);
    cyc(1'b0, 1'b1, 8'h79);
    cyc(1'b0, 1'b1, 8'h7A);
    chk("frame_idle_wrEn", 64'(wrEn), 64'd0);
    chk("frame_idle_busy", 64'(busy), 64'd0);
    chk("frame_idle_done", 64'(done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
